// File: rtl/uart_transceiver.sv
// rtl/uart_transceiver.sv - 8N1 UART transceiver: 16x-oversampled RX with start-glitch filter, bit-timed TX.
// Optional UART_FRAME_ERR_EN adds a frame_err pulse and break handling on a bad stop bit.
module uart_transceiver #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       wr_en,
  output logic       tx,
  output logic       tx_busy,
  input  logic       rx,
  output logic       rx_rdy,
  input  logic       rx_rdy_clr,
  output logic [7:0] dout
`ifdef UART_FRAME_ERR_EN
  ,
  output logic       frame_err
`endif
);

  localparam int RX_DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int TX_DIV = CLK_FREQ / BAUD;
  localparam int RDW    = (RX_DIV > 1) ? $clog2(RX_DIV) : 1;
  localparam int TDW    = (TX_DIV > 1) ? $clog2(TX_DIV) : 1;
  localparam int SW     = $clog2(OVERSAMPLE);

  localparam logic [RDW-1:0] RX_DIV_LAST = RDW'(RX_DIV - 1);
  localparam logic [TDW-1:0] TX_DIV_LAST = TDW'(TX_DIV - 1);
  localparam logic [SW-1:0]  HALF_LAST   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0]  FULL_LAST   = SW'(OVERSAMPLE - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [RDW-1:0] rx_div_cnt;
  logic           rx_tick;
  logic           rx_meta;
  logic           rx_sync;
  logic [1:0]     rx_state;
  logic [SW-1:0]  rx_cnt;
  logic [2:0]     rx_bit;
  logic [7:0]     rx_shift;
`ifdef UART_FRAME_ERR_EN
  logic           rx_wait_high;
`endif

  logic [1:0]     tx_state;
  logic [TDW-1:0] tx_cnt;
  logic [2:0]     tx_bit;
  logic [7:0]     tx_shift;

  // Free-running oversample tick; with RX_DIV=1 it is high every cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_div_cnt <= '0;
      rx_tick    <= 1'b0;
    end else if (rx_div_cnt == RX_DIV_LAST) begin
      rx_div_cnt <= '0;
      rx_tick    <= 1'b1;
    end else begin
      rx_div_cnt <= rx_div_cnt + 1'b1;
      rx_tick    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_state     <= S_IDLE;
      rx_cnt       <= '0;
      rx_bit       <= '0;
      rx_shift     <= '0;
      rx_rdy       <= 1'b0;
      dout         <= '0;
`ifdef UART_FRAME_ERR_EN
      rx_wait_high <= 1'b0;
      frame_err    <= 1'b0;
`endif
    end else begin
      // A completing byte below overrides this clear.
      if (rx_rdy_clr) rx_rdy <= 1'b0;
`ifdef UART_FRAME_ERR_EN
      frame_err <= 1'b0;
`endif
      case (rx_state)
        S_IDLE: begin
          rx_cnt <= '0;
          rx_bit <= '0;
`ifdef UART_FRAME_ERR_EN
          if (rx_wait_high) begin
            if (rx_sync) rx_wait_high <= 1'b0;
          end else if (!rx_sync) begin
            rx_state <= S_START;
          end
`else
          if (!rx_sync) rx_state <= S_START;
`endif
        end
        S_START: if (rx_tick) begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_state <= rx_sync ? S_IDLE : S_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        S_DATA: if (rx_tick) begin
          if (rx_cnt == FULL_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= S_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        S_STOP: if (rx_tick) begin
          if (rx_cnt == FULL_LAST) begin
            rx_cnt   <= '0;
            rx_state <= S_IDLE;
`ifdef UART_FRAME_ERR_EN
            if (rx_sync) begin
              dout   <= rx_shift;
              rx_rdy <= 1'b1;
            end else begin
              frame_err    <= 1'b1;
              rx_wait_high <= 1'b1;
            end
`else
            dout   <= rx_shift;
            rx_rdy <= 1'b1;
`endif
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      case (tx_state)
        S_IDLE: begin
          if (wr_en) begin
            tx_shift <= din;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx       <= 1'b0;
            tx_busy  <= 1'b1;
            tx_state <= S_START;
          end
        end
        S_START: begin
          if (tx_cnt == TX_DIV_LAST) begin
            tx_cnt   <= '0;
            tx       <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_state <= S_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (tx_cnt == TX_DIV_LAST) begin
            tx_cnt <= '0;
            tx_bit <= tx_bit + 3'd1;
            if (tx_bit == 3'd7) begin
              tx       <= 1'b1;
              tx_state <= S_STOP;
            end else begin
              tx       <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (tx_cnt == TX_DIV_LAST) begin
            tx_cnt   <= '0;
            tx_busy  <= 1'b0;
            tx_state <= S_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transceiver.sv
// tb/tb_uart_transceiver.sv - scoreboard bench for uart_transceiver at 16 clocks per bit.
module tb_uart_transceiver;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] din = 8'h00;
  logic       wr_en = 1'b0;
  logic       tx;
  logic       tx_busy;
  logic       rx_drv = 1'b1;
  logic       loop_en = 1'b0;
  logic       rx_line;
  logic       rx_rdy;
  logic       rx_rdy_clr = 1'b0;
  logic [7:0] dout;
`ifdef UART_FRAME_ERR_EN
  logic       frame_err;
`endif

  int tests = 0;
  int fails = 0;
  int rise_cnt = 0;
  int ferr_cnt = 0;
  int r0;
  int f0;
  logic [7:0] d0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] lb_bytes[3] = '{8'h00, 8'hFF, 8'h81};

  int         tx_c;
  logic [9:0] tx_bits;
  logic       tx_lvl;
  logic       tx_stable;
  logic       busy_prev = 1'b0;
  logic       rdy_prev = 1'b0;
  logic [7:0] tx_e;
  logic [7:0] rx_e;

  assign rx_line = loop_en ? tx : rx_drv;

  always #5 clk = ~clk;

  uart_transceiver #(.CLK_FREQ(1600), .BAUD(100), .OVERSAMPLE(16)) dut (
    .clk(clk),
    .rst(rst),
    .din(din),
    .wr_en(wr_en),
    .tx(tx),
    .tx_busy(tx_busy),
    .rx(rx_line),
    .rx_rdy(rx_rdy),
    .rx_rdy_clr(rx_rdy_clr),
    .dout(dout)
`ifdef UART_FRAME_ERR_EN
    ,
    .frame_err(frame_err)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    rx_drv = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      tick(16);
    end
    rx_drv = stop_bit;
    tick(16);
    rx_drv = 1'b1;
  endtask

  task automatic write_tx(input logic [7:0] b);
    din   = b;
    wr_en = 1'b1;
    tick(1);
    wr_en = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (tx_busy && n < 400) begin
      tick(1);
      n++;
    end
    if (n >= 400) check("tx_busy_timeout", {31'h0, tx_busy}, 32'h0);
  endtask

  // TX monitor: decode each frame mid-bit and measure its busy length.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst && tx_busy && !busy_prev) begin
        tx_c      = 0;
        tx_stable = 1'b1;
        tx_lvl    = 1'b0;
        tx_bits   = '0;
        while (tx_busy && tx_c < 400) begin
          if (tx_c % 16 == 0) tx_lvl = tx;
          else if (tx !== tx_lvl) tx_stable = 1'b0;
          if (tx_c % 16 == 8 && tx_c < 160) tx_bits[tx_c / 16] = tx;
          @(posedge clk);
          #1;
          tx_c++;
        end
        if (rst) begin
          if (tx_q.size() == 0) begin
            check("tx_unexpected_frame", tx_q.size(), 1);
          end else begin
            tx_e = tx_q.pop_front();
            check("tx_frame_bits", {22'h0, tx_bits}, {22'h0, 1'b1, tx_e, 1'b0});
            check("tx_busy_len", tx_c, 160);
            check("tx_level_held", {31'h0, tx_stable}, 32'h1);
          end
        end
      end
      busy_prev = tx_busy;
    end
  end

  // RX monitor: every rising rx_rdy is matched against the next expected byte.
  initial begin
    forever begin
      @(posedge clk);
      #1;
`ifdef UART_FRAME_ERR_EN
      if (frame_err) ferr_cnt++;
`endif
      if (rst && rx_rdy && !rdy_prev) begin
        rise_cnt++;
        if (rx_q.size() == 0) begin
          check("rx_unexpected_byte", rx_q.size(), 1);
        end else begin
          rx_e = rx_q.pop_front();
          check("rx_byte", {24'h0, dout}, {24'h0, rx_e});
        end
      end
      rdy_prev = rx_rdy;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tick(3);
    check("reset_tx", {31'h0, tx}, 32'h1);
    check("reset_busy", {31'h0, tx_busy}, 32'h0);
    rst = 1'b1;
    tick(2);

    write_tx(8'hFF);
    tick(40);
    rst = 1'b0;
    tick(5);
    rst = 1'b1;
    tick(1);
    check("midtx_reset_tx", {31'h0, tx}, 32'h1);
    check("midtx_reset_busy", {31'h0, tx_busy}, 32'h0);
    check("midtx_reset_rdy", {31'h0, rx_rdy}, 32'h0);
    check("midtx_reset_dout", {24'h0, dout}, 32'h0);
    tick(5);

    tx_q.push_back(8'hA5);
    write_tx(8'hA5);
    wait_idle();
    tick(4);

    tx_q.push_back(8'h3C);
    din   = 8'h3C;
    wr_en = 1'b1;
    tick(3);
    din   = 8'h00;
    wr_en = 1'b0;
    wait_idle();
    tx_q.push_back(8'h96);
    write_tx(8'h96);
    check("tx_restart_busy", {31'h0, tx_busy}, 32'h1);
    check("tx_restart_start", {31'h0, tx}, 32'h0);
    wait_idle();
    tick(20);

    rx_q.push_back(8'h5A);
    send_rx(8'h5A, 1'b1);
    check("rx_rdy_set", {31'h0, rx_rdy}, 32'h1);
    check("rx_dout_5a", {24'h0, dout}, 32'h5A);
    rx_rdy_clr = 1'b1;
    tick(1);
    rx_rdy_clr = 1'b0;
    check("rx_rdy_cleared", {31'h0, rx_rdy}, 32'h0);

    r0 = rise_cnt;
    rx_drv = 1'b0;
    tick(4);
    rx_drv = 1'b1;
    tick(40);
    check("glitch_no_byte", rise_cnt - r0, 0);
    check("glitch_rdy", {31'h0, rx_rdy}, 32'h0);

    rx_q.push_back(8'h11);
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    check("overrun_dout", {24'h0, dout}, 32'h22);
    check("overrun_rdy", {31'h0, rx_rdy}, 32'h1);

    r0 = rise_cnt;
    rx_q.push_back(8'hC3);
    rx_rdy_clr = 1'b1;
    send_rx(8'hC3, 1'b1);
    check("set_wins_over_clr", rise_cnt - r0, 1);
    check("clr_held_rdy", {31'h0, rx_rdy}, 32'h0);
    rx_rdy_clr = 1'b0;
    tick(20);

    r0 = rise_cnt;
    loop_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tx_q.push_back(lb_bytes[i]);
      rx_q.push_back(lb_bytes[i]);
      write_tx(lb_bytes[i]);
      wait_idle();
      rx_rdy_clr = 1'b1;
      tick(1);
      rx_rdy_clr = 1'b0;
      tick(2);
    end
    check("loopback_count", rise_cnt - r0, 3);
    loop_en = 1'b0;
    tick(10);

`ifdef UART_FRAME_ERR_EN
    d0 = dout;
    f0 = ferr_cnt;
    send_rx(8'h5E, 1'b0);
    tick(10);
    check("frame_err_pulses", ferr_cnt - f0, 1);
    check("frame_err_dout", {24'h0, dout}, {24'h0, d0});
    check("frame_err_rdy", {31'h0, rx_rdy}, 32'h0);
`endif

    tick(50);
    check("tx_queue_drained", tx_q.size(), 0);
    check("rx_queue_drained", rx_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
